// File: rtl/softmax_argmax.sv
// Argmax over the ten single-precision softmax outputs: captures the vector,
// scans one element per clock and reports index, value and a NaN flag.
module softmax_argmax #(
   parameter int DATA_WIDTH = 32,
   parameter int INPUT_NUM  = 10
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DATA_WIDTH*INPUT_NUM-1:0] inputs,
   input  logic                            enable,
   output logic [3:0]                      class_idx,
   output logic [DATA_WIDTH-1:0]           max_value,
   output logic                            nan_flag,
   output logic                            ack
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [3:0]            LAST = 4'(INPUT_NUM - 1);
   localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(32'h7FC0_0000);

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [DATA_WIDTH-1:0] cap_q [INPUT_NUM];
   logic [DATA_WIDTH-1:0] best_q;
   logic [3:0]            best_idx_q;
   logic                  empty_q;
   logic [3:0]            class_idx_q;
   logic [DATA_WIDTH-1:0] max_value_q;
   logic                  nan_q;
   logic                  ack_q;

   logic [DATA_WIDTH-1:0] elem_d;
   logic                  take_d;
   logic [DATA_WIDTH-1:0] best_d;
   logic [3:0]            best_idx_d;
   logic                  empty_d;

   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Sign-magnitude ordering; +0 and -0 compare equal so they never displace each other.
   function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
      if (a[31] != b[31]) return !a[31];
      if (!a[31]) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   always_comb begin
      elem_d     = cap_q[cnt_q];
      take_d     = !is_nan(elem_d) && (empty_q || gt(elem_d, best_q));
      best_d     = take_d ? elem_d : best_q;
      best_idx_d = take_d ? cnt_q : best_idx_q;
      empty_d    = empty_q && !take_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         for (int i = 0; i < INPUT_NUM; i++) cap_q[i] <= '0;
         best_q      <= '0;
         best_idx_q  <= 4'd0;
         empty_q     <= 1'b0;
         class_idx_q <= 4'd0;
         max_value_q <= '0;
         nan_q       <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q <= 1'b0;
               if (enable) begin
                  for (int i = 0; i < INPUT_NUM; i++)
                     cap_q[i] <= inputs[i*DATA_WIDTH +: DATA_WIDTH];
                  best_q     <= inputs[DATA_WIDTH-1:0];
                  best_idx_q <= 4'd0;
                  empty_q    <= is_nan(inputs[DATA_WIDTH-1:0]);
                  nan_q      <= is_nan(inputs[DATA_WIDTH-1:0]);
                  cnt_q      <= 4'd1;
                  state_q    <= SCAN;
               end
            end
            SCAN: begin
               if (!enable) begin
                  ack_q   <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  best_q     <= best_d;
                  best_idx_q <= best_idx_d;
                  empty_q    <= empty_d;
                  nan_q      <= nan_q | is_nan(elem_d);
                  cnt_q      <= cnt_q + 4'd1;
                  if (cnt_q == LAST) begin
                     class_idx_q <= best_idx_d;
                     max_value_q <= empty_d ? QNAN : best_d;
                     ack_q       <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (!enable) begin
                  ack_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign class_idx = class_idx_q;
   assign max_value = max_value_q;
   assign nan_flag  = nan_q;
   assign ack       = ack_q;

endmodule

// File: tb/tb_softmax_argmax.sv
// Directed bench for softmax_argmax: hand-computed argmax vectors, latency,
// abort, asynchronous reset and capture isolation.
module tb_softmax_argmax;

   logic         clk;
   logic         rst_n;
   logic [319:0] inputs;
   logic         enable;
   logic [3:0]   class_idx;
   logic [31:0]  max_value;
   logic         nan_flag;
   logic         ack;

   logic [31:0]  v [10];
   int           errors = 0;
   int           checks = 0;

   softmax_argmax #(.DATA_WIDTH(32), .INPUT_NUM(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inputs    (inputs),
      .enable    (enable),
      .class_idx (class_idx),
      .max_value (max_value),
      .nan_flag  (nan_flag),
      .ack       (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < 10; i++) inputs[i*32 +: 32] = v[i];
   endtask

   task automatic fill(input logic [31:0] x);
      for (int i = 0; i < 10; i++) v[i] = x;
   endtask

   // Full scan: raise enable, count edges to ack, check result, then release.
   task automatic run(input string tag, input logic [3:0] e_idx, input logic [31:0] e_max,
                      input logic e_nan, input bit scramble);
      int n;
      pack();
      @(negedge clk);
      enable = 1'b1;
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (n == 1 && scramble) inputs = {10{32'h7F00_0000}};
         if (ack) break;
      end
      chk({tag, "_lat"}, 32'(n), 32'd10);
      chk({tag, "_idx"}, 32'(class_idx), 32'(e_idx));
      chk({tag, "_max"}, max_value, e_max);
      chk({tag, "_nan"}, 32'(nan_flag), 32'(e_nan));
      @(posedge clk); #1;
      chk({tag, "_hold"}, 32'(ack), 32'd1);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_drop"}, 32'(ack), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      inputs = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_idx", 32'(class_idx), 32'd0);
      chk("rst_max", max_value, 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_ack", 32'(ack), 32'd0);

      // 1: i*0.1 ramp
      v[0] = 32'h0000_0000; v[1] = 32'h3DCC_CCCD; v[2] = 32'h3E4C_CCCD; v[3] = 32'h3E99_999A;
      v[4] = 32'h3ECC_CCCD; v[5] = 32'h3F00_0000; v[6] = 32'h3F19_999A; v[7] = 32'h3F33_3333;
      v[8] = 32'h3F4C_CCCD; v[9] = 32'h3F66_6666;
      run("ramp", 4'd9, 32'h3F66_6666, 1'b0, 1'b0);

      // 2: tie at 0.5 resolves to lowest index
      fill(32'h3DCC_CCCD); v[3] = 32'h3F00_0000; v[7] = 32'h3F00_0000;
      run("tie", 4'd3, 32'h3F00_0000, 1'b0, 1'b0);

      // 3a: all negative, -1.0 is the maximum
      fill(32'hC000_0000); v[1] = 32'hC040_0000; v[8] = 32'hBFC0_0000; v[5] = 32'hBF80_0000;
      run("neg", 4'd5, 32'hBF80_0000, 1'b0, 1'b0);

      // 3b: -0 at 2 and +0 at 4 are equal, so index 2 wins
      fill(32'hC000_0000); v[2] = 32'h8000_0000; v[4] = 32'h0000_0000;
      run("zero", 4'd2, 32'h8000_0000, 1'b0, 1'b0);

      // 4a: leading NaN is skipped but flagged
      fill(32'h3E00_0000); v[0] = 32'h7FC0_0000; v[6] = 32'h3F40_0000;
      run("nan0", 4'd6, 32'h3F40_0000, 1'b1, 1'b0);

      // 4b: all NaN
      fill(32'h7FC0_0000); v[3] = 32'hFF80_0001;
      run("allnan", 4'd0, 32'h7FC0_0000, 1'b1, 1'b0);

      // infinity is an ordinary maximum; a trailing NaN still sets the flag
      fill(32'h3F80_0000); v[8] = 32'h7F80_0000; v[9] = 32'h7F80_0001;
      run("inf", 4'd8, 32'h7F80_0000, 1'b1, 1'b0);

      // 5: abort on the 5th scan edge; previous result must survive
      fill(32'h3E00_0000); v[1] = 32'h3F00_0000;
      pack();
      @(negedge clk);
      enable = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_ack", 32'(ack), 32'd0);
      end
      chk("abort_idx", 32'(class_idx), 32'd8);
      fill(32'h3E00_0000); v[4] = 32'h3F00_0000;
      run("rerun", 4'd4, 32'h3F00_0000, 1'b0, 1'b0);

      // 6: asynchronous reset between edges mid-scan
      fill(32'h3E00_0000); v[7] = 32'h3F00_0000;
      pack();
      @(negedge clk);
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_idx", 32'(class_idx), 32'd0);
      chk("arst_max", max_value, 32'd0);
      chk("arst_ack", 32'(ack), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_idle", 32'(ack), 32'd0);

      // captured values only: inputs scrambled after the capture edge
      fill(32'h3E00_0000); v[2] = 32'h3F00_0000;
      run("capt", 4'd2, 32'h3F00_0000, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
